blink_detect: RTL and testbench

Receive-side monitor for the LED blink generator. It samples an asynchronous `led_in` toggle line and measures the number of `clk` cycles between toggles. It checks each interval against the expected half-period of 2^CBITS cycles and reports lock and error status. It sits on the board-test/self-check path, downstream of a blink generator or an external LED line.

---
 rtl/blink_detect.sv | 147 ++++++++++++++
 tb/tb_blink_detect.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/blink_detect.sv
// blink_detect: times led_in toggles against a 2^CBITS half-period and tracks lock/error status.
// Optional saturating error counter (err_cnt port) enabled by BLINK_DETECT_STATS_EN.
module blink_detect #(
  parameter int CBITS  = 15,
  parameter int TOL    = 2,
  parameter int LOCK_N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           led_in,
  output logic           edge_flg,
  output logic [CBITS:0] half_per,
  output logic           locked,
  output logic           err
`ifdef BLINK_DETECT_STATS_EN
  ,
  output logic [7:0]     err_cnt
`endif
);

  // Window bounds are one bit wider than cnt so EXP +/- TOL and the timeout point never wrap.
  localparam logic [CBITS+1:0] EXP_W  = {2'b01, {CBITS{1'b0}}};
  localparam logic [CBITS+1:0] TOL_W  = (CBITS+2)'(TOL);
  localparam logic [CBITS+1:0] LO_W   = EXP_W - TOL_W;
  localparam logic [CBITS+1:0] HI_W   = EXP_W + TOL_W;
  localparam logic [CBITS+1:0] TO_W   = HI_W + (CBITS+2)'(1);
  localparam logic [3:0]       LOCK_W = 4'(LOCK_N);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  logic             s1_q, s2_q, s3_q;
  logic [CBITS:0]   cnt_q, cnt_d;
  logic [CBITS+1:0] cnt_ext;
  logic             edge_det, good, timeout;
  logic             edge_flg_q, locked_q, err_q;
  logic [CBITS:0]   half_per_q;
  logic [3:0]       gcnt_q;
  state_t           state_q;

  assign edge_det = s2_q ^ s3_q;
  assign cnt_ext  = {1'b0, cnt_q};
  assign good     = (cnt_ext >= LO_W) && (cnt_ext <= HI_W);
  assign timeout  = !edge_det && (cnt_ext == TO_W);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_det) begin
      cnt_d = (CBITS+1)'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + (CBITS+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      cnt_q      <= '0;
      half_per_q <= '0;
      edge_flg_q <= 1'b0;
    end else begin
      s1_q       <= led_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      cnt_q      <= cnt_d;
      edge_flg_q <= edge_det;
      if (edge_det) begin
        half_per_q <= cnt_q;
      end
    end
  end

  // An edge always wins over timeout, so an edge at EXP+TOL+1 is simply a bad interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      gcnt_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (edge_det) begin
            state_q <= ACQUIRE;
            gcnt_q  <= '0;
          end
        end
        ACQUIRE: begin
          if (edge_det) begin
            if (good) begin
              gcnt_q <= gcnt_q + 4'd1;
              if (gcnt_q + 4'd1 == LOCK_W) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              gcnt_q <= '0;
            end
          end else if (timeout) begin
            state_q <= SEARCH;
          end
        end
        LOCKED: begin
          if (edge_det && !good) begin
            err_q    <= 1'b1;
            locked_q <= 1'b0;
            state_q  <= ACQUIRE;
            gcnt_q   <= '0;
          end else if (timeout) begin
            err_q    <= 1'b1;
            locked_q <= 1'b0;
            state_q  <= SEARCH;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BLINK_DETECT_STATS_EN
  logic [7:0] err_cnt_q;
  logic       err_now;

  assign err_now = (state_q == LOCKED) && ((edge_det && !good) || timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_now && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign edge_flg = edge_flg_q;
  assign half_per = half_per_q;
  assign locked   = locked_q;
  assign err      = err_q;

endmodule

// File: tb/tb_blink_detect.sv
// Bench for blink_detect: interval-level reference model driven by directed and random toggle gaps.
`timescale 1ns/1ps
module tb_blink_detect;
  localparam int CBITS    = 4;
  localparam int TOL      = 1;
  localparam int LOCK_N   = 3;
  localparam int EXP      = 16;
  localparam int HALF_MAX = 31;
  // Timeout err becomes visible 21 sampled cycles after the toggle that started the interval.
  localparam int TO_SEEN  = 21;
  localparam int S_SEARCH = 0, S_ACQ = 1, S_LOCKED = 2;

  logic clk = 1'b0;
  logic rst, led_in;
  logic edge_flg, locked, err;
  logic [CBITS:0] half_per;
`ifdef BLINK_DETECT_STATS_EN
  logic [7:0] err_cnt;
`endif

  blink_detect #(.CBITS(CBITS), .TOL(TOL), .LOCK_N(LOCK_N)) dut (
    .clk      (clk),
    .rst      (rst),
    .led_in   (led_in),
    .edge_flg (edge_flg),
    .half_per (half_per),
    .locked   (locked),
    .err      (err)
`ifdef BLINK_DETECT_STATS_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_state, m_gcnt, m_pend, m_errtot, m_since, err_extra;
  bit m_have_prev;

  function automatic bit in_tol(input int n);
    return (n >= EXP - TOL) && (n <= EXP + TOL);
  endfunction

  function automatic int sat8(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic model_reset();
    m_state = S_SEARCH; m_gcnt = 0; m_pend = 0; m_errtot = 0;
    m_since = 0; err_extra = 0; m_have_prev = 0;
  endtask

  // Toggle (or, right after reset release with led_in high, just let the sync edge happen), then
  // sample n cycles; the edge being evaluated closes the interval of m_since cycles.
  task automatic step(input int n, input bit flip);
    int  interval;
    int  exp_hp;
    bit  exp_err;
    bit  chk_hp;
    interval = m_since;
    exp_err  = 1'b0;
    chk_hp   = m_have_prev;
    if (m_state != S_SEARCH && interval > EXP + TOL + 1) begin
      if (m_state == S_LOCKED) begin m_pend++; m_errtot++; end
      m_state = S_SEARCH;
    end
    case (m_state)
      S_SEARCH: begin m_state = S_ACQ; m_gcnt = 0; end
      S_ACQ: begin
        if (in_tol(interval)) begin
          m_gcnt++;
          if (m_gcnt == LOCK_N) m_state = S_LOCKED;
        end else begin
          m_gcnt = 0;
        end
      end
      default: begin
        if (!in_tol(interval)) begin
          exp_err = 1'b1; m_errtot++; m_state = S_ACQ; m_gcnt = 0;
        end
      end
    endcase
    exp_hp = (interval > HALF_MAX) ? HALF_MAX : interval;
    if (flip) led_in = ~led_in;
    m_since = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      m_since++;
      if (i == 3) begin
        total++;
        if (edge_flg !== 1'b1) begin bad++; $display("FAIL edge_pulse: got %b want 1 (interval %0d)", edge_flg, interval); end
        total++;
        if (err_extra !== m_pend) begin bad++; $display("FAIL timeout_err: got %0d pulses want %0d", err_extra, m_pend); end
        err_extra = 0; m_pend = 0;
        total++;
        if (err !== exp_err) begin bad++; $display("FAIL edge_err: got %b want %b (interval %0d)", err, exp_err, interval); end
        total++;
        if (locked !== (m_state == S_LOCKED)) begin bad++; $display("FAIL edge_locked: got %b want %b (interval %0d)", locked, (m_state == S_LOCKED), interval); end
        if (chk_hp) begin
          total++;
          if (half_per !== (CBITS+1)'(exp_hp)) begin bad++; $display("FAIL half_per: got %0d want %0d", half_per, exp_hp); end
        end
`ifdef BLINK_DETECT_STATS_EN
        total++;
        if (err_cnt !== 8'(sat8(m_errtot))) begin bad++; $display("FAIL err_cnt: got %0d want %0d", err_cnt, sat8(m_errtot)); end
`endif
        $display("edge interval=%0d half_per=%0d locked=%b err=%b", interval, half_per, locked, err);
      end else begin
        total++;
        if (edge_flg !== 1'b0) begin bad++; $display("FAIL stray_edge: got %b want 0 (cycle %0d after toggle)", edge_flg, i); end
        if (err === 1'b1) err_extra++;
      end
    end
    m_have_prev = 1'b1;
  endtask

  // Hold led_in steady for m cycles and check the timeout outcome.
  task automatic flush(input int m);
    for (int i = 0; i < m; i++) begin
      @(negedge clk);
      m_since++;
      total++;
      if (edge_flg !== 1'b0) begin bad++; $display("FAIL idle_edge: got %b want 0", edge_flg); end
      if (err === 1'b1) err_extra++;
    end
    if (m_state != S_SEARCH && m_since >= TO_SEEN) begin
      if (m_state == S_LOCKED) begin m_pend++; m_errtot++; end
      m_state = S_SEARCH;
    end
    total++;
    if (err_extra !== m_pend) begin bad++; $display("FAIL idle_err: got %0d pulses want %0d", err_extra, m_pend); end
    total++;
    if (locked !== (m_state == S_LOCKED)) begin bad++; $display("FAIL idle_locked: got %b want %b", locked, (m_state == S_LOCKED)); end
`ifdef BLINK_DETECT_STATS_EN
    total++;
    if (err_cnt !== 8'(sat8(m_errtot))) begin bad++; $display("FAIL idle_err_cnt: got %0d want %0d", err_cnt, sat8(m_errtot)); end
`endif
    $display("idle %0d cycles: locked=%b err_pulses=%0d", m, locked, err_extra);
    err_extra = 0; m_pend = 0;
  endtask

  task automatic check_cleared(input string tag);
    total++;
    if (edge_flg !== 1'b0) begin bad++; $display("FAIL %s_edge_flg: got %b want 0", tag, edge_flg); end
    total++;
    if (half_per !== '0) begin bad++; $display("FAIL %s_half_per: got %0d want 0", tag, half_per); end
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL %s_locked: got %b want 0", tag, locked); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL %s_err: got %b want 0", tag, err); end
`ifdef BLINK_DETECT_STATS_EN
    total++;
    if (err_cnt !== 8'd0) begin bad++; $display("FAIL %s_err_cnt: got %0d want 0", tag, err_cnt); end
`endif
    $display("%s: outputs edge_flg=%b half_per=%0d locked=%b err=%b", tag, edge_flg, half_per, locked, err);
  endtask

  task automatic test_reset();
    rst = 1'b1; led_in = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    model_reset();
    flush(40);
  endtask

  task automatic test_lock();
    repeat (6) step(16, 1'b1);
  endtask

  task automatic test_long_interval();
    step(20, 1'b1);
    repeat (5) step(16, 1'b1);
  endtask

  task automatic test_hold();
    flush(40);
    repeat (5) step(16, 1'b1);
  endtask

  task automatic test_tolerance();
    int gaps [12] = '{15, 17, 16, 14, 16, 16, 18, 16, 16, 16, 16, 16};
    foreach (gaps[k]) step(gaps[k], 1'b1);
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 80; k++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      step(16, 1'b1);
      else if (r == 6) step(($urandom_range(0, 1) != 0) ? 15 : 17, 1'b1);
      else if (r == 7) step(($urandom_range(0, 1) != 0) ? 14 : 18, 1'b1);
      else if (r == 8) step(int'($urandom_range(19, 24)), 1'b1);
      else begin
        step(16, 1'b1);
        flush(30);
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (5) step(16, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_cleared("async_reset");
    led_in = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    // With led_in already high the synchronizer produces the first SEARCH edge on its own.
    step(16, (led_in == 1'b0));
    repeat (5) step(16, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    led_in = 1'b0;
    model_reset();
    test_reset();
    test_lock();
    test_long_interval();
    test_hold();
    test_tolerance();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
